// File: rtl/alu_with_mux.sv
// rtl/alu_with_mux.sv - registered 4-op ALU (add/sub/and/or) with flags and one-cycle latency
// Operation selected by a 4-way mux; result and flags captured only when in_valid is high.
module alu_with_mux #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_q, negative_q, out_valid_q;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  // Bit WIDTH of the extended difference is set exactly when A < B unsigned.
  assign diff_ext = {1'b0, A} - {1'b0, B};

  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    unique case (select)
      2'b00: begin
        result_d   = sum_ext[WIDTH-1:0];
        carry_d    = sum_ext[WIDTH];
        overflow_d = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      2'b01: begin
        result_d   = diff_ext[WIDTH-1:0];
        carry_d    = diff_ext[WIDTH];
        overflow_d = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);
      end
      2'b10: result_d = A & B;
      2'b11: result_d = A | B;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q   <= result_d;
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        zero_q     <= (result_d == '0);
        negative_q <= result_d[MSB];
      end
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_with_mux.sv
// tb/tb_alu_with_mux.sv - self-checking bench for alu_with_mux
// Directed vectors plus random traffic against an integer-arithmetic reference model.
module tb_alu_with_mux;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [1:0]   select = 2'b00;
  logic [W-1:0] result;
  logic         out_valid, carry, zero, negative, overflow;

  int n_cmp = 0;
  int n_err = 0;

  int e_res = 0;
  int e_c = 0, e_z = 0, e_n = 0, e_o = 0, e_v = 0;

  alu_with_mux #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .select   (select),
    .result   (result),
    .out_valid(out_valid),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".result"},    32'(result),    32'(e_res));
    check({tag, ".carry"},     32'(carry),     32'(e_c));
    check({tag, ".zero"},      32'(zero),      32'(e_z));
    check({tag, ".negative"},  32'(negative),  32'(e_n));
    check({tag, ".overflow"},  32'(overflow),  32'(e_o));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_v));
  endtask

  // Reference: plain integer arithmetic, signed overflow from range check.
  task automatic model(input int v, input int a, input int b, input int s);
    int sa, sb, r, sr;
    if (v == 0) begin
      e_v = 0;
      return;
    end
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r = 0; sr = 0; e_c = 0; e_o = 0;
    case (s)
      0: begin r = a + b; e_c = (r > 15); sr = sa + sb; e_o = (sr > 7 || sr < -8); end
      1: begin r = a - b; e_c = (a < b);  sr = sa - sb; e_o = (sr > 7 || sr < -8); end
      2: r = a & b;
      default: r = a | b;
    endcase
    e_res = r & 15;
    e_z = (e_res == 0);
    e_n = (e_res >= 8);
    e_v = 1;
  endtask

  // Called at a negedge: drive inputs, advance one edge, check at next negedge.
  task automatic cycle(input int v, input int a, input int b, input int s, input string tag);
    in_valid = v[0];
    A = W'(a);
    B = W'(b);
    select = 2'(s);
    model(v, a, b, s);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    #2;
    check("rst.result", 32'(result), 0);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.zero", 32'(zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("idle");

    cycle(1, 3, 5, 0, "add35");
    check("add35.lit", 32'(result), 32'h8);
    check("add35.ovf_lit", 32'(overflow), 1);
    cycle(1, 3, 5, 1, "sub35");
    check("sub35.lit", 32'(result), 32'hE);
    check("sub35.borrow_lit", 32'(carry), 1);
    cycle(1, 3, 5, 2, "and35");
    check("and35.lit", 32'(result), 32'h1);
    cycle(1, 3, 5, 3, "or35");
    check("or35.lit", 32'(result), 32'h7);
    cycle(1, 15, 1, 0, "addwrap");
    check("addwrap.lit", 32'({carry, zero, overflow}), 32'b110);
    cycle(1, 5, 5, 1, "subzero");
    check("subzero.lit", 32'({carry, zero}), 32'b01);

    cycle(1, 3, 5, 0, "hold_cap");
    for (int i = 0; i < 3; i++) begin
      cycle(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), "hold");
      check("hold.lit", 32'(result), 32'h8);
    end

    // Reset asserted mid-period while out_valid is high; op issued in that cycle is dropped.
    in_valid = 1'b1; A = 4'd3; B = 4'd5; select = 2'b00;
    model(1, 3, 5, 0);
    @(posedge clk);
    #2;
    check("pre_rst.out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    A = 4'd15; B = 4'd1;
    #1;
    check("async_rst", 32'({result, carry, zero, negative, overflow, out_valid}), 0);
    @(negedge clk);
    check("rst_hold", 32'({result, carry, zero, negative, overflow, out_valid}), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    e_res = 0; e_c = 0; e_z = 0; e_n = 0; e_o = 0; e_v = 0;
    @(negedge clk);
    check_outputs("post_rst");

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 3), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_with_mux.md
ALU_WITH_MUX -- requirements
Module: alu_with_mux

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; all requirements and examples below use WIDTH=4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  qualifies A, B and select for capture this cycle.
REQ-005 A  input  WIDTH  operand A, unsigned/two's-complement.
REQ-006 B  input  WIDTH  operand B, unsigned/two's-complement.
REQ-007 select  input  2  operation code.
REQ-008 result  output  WIDTH  registered operation result.
REQ-009 out_valid  output  1  high for exactly one cycle per captured operation.
REQ-010 carry  output  1  registered carry (add) / borrow (sub) flag.
REQ-011 zero  output  1  registered flag, result == 0.
REQ-012 negative  output  1  registered flag, result MSB.
REQ-013 overflow  output  1  registered signed-overflow flag.
REQ-014 The design SHALL use one clock and an asynchronous, active-low reset; the polarity and synchronicity are fixed.

Function
REQ-015 select=00 SHALL compute A+B modulo 2^WIDTH; carry = bit WIDTH of the full sum.
REQ-016 select=01 SHALL compute A-B modulo 2^WIDTH, two's complement; carry = borrow = 1 when A < B unsigned.
REQ-017 select=10 SHALL compute bitwise A & B; carry = 0, overflow = 0.
REQ-018 select=11 SHALL compute bitwise A | B; carry = 0, overflow = 0.
REQ-019 The operation SHALL be selected by a 4-way multiplexer on select; no select value is illegal.
REQ-020 Overflow for add SHALL be 1 when A and B MSBs are equal and the result MSB differs; for sub, 1 when A and B MSBs differ and the result MSB differs from A's MSB.
REQ-021 zero SHALL be 1 exactly when the WIDTH-bit result is all zeros; negative SHALL equal result[WIDTH-1], for all ops.
REQ-022 Latency SHALL be one cycle: inputs sampled at rising edge N with in_valid=1 appear on result/flags with out_valid=1 after edge N.
REQ-023 With in_valid=0 at an edge, result and all flags SHALL hold their previous values and out_valid SHALL be 0.
REQ-024 Back-to-back in_valid=1 SHALL be accepted every cycle with no bubbles; no backpressure exists.
REQ-025 Inputs SHALL not affect outputs combinationally; all outputs are driven directly from registers.

Reset
REQ-026 While rst_n=0, result, carry, zero-flag-register, negative, overflow and out_valid SHALL be 0 immediately, independent of clk; zero SHALL read 0 during reset.
REQ-027 After rst_n deasserts, the first capture SHALL occur on the first rising edge with in_valid=1; an operation pending when reset asserts SHALL be discarded.

Verification
REQ-028 A=0011, B=0101, select=00, in_valid=1 -> next cycle result=1000, carry=0, zero=0, negative=1, overflow=1, out_valid=1.
REQ-029 Same operands, select=01 -> result=1110, carry(borrow)=1, negative=1, overflow=0; select=10 -> result=0001; select=11 -> result=0111, carry=0.
REQ-030 A=1111, B=0001, select=00 -> result=0000, carry=1, zero=1, overflow=0; A=0101, B=0101, select=01 -> result=0000, carry=0, zero=1.
REQ-031 Capture A=0011, B=0101, select=00, then in_valid=0 for 3 cycles with changing inputs -> result stays 1000, out_valid=0 for those cycles.
REQ-032 Four consecutive cycles in_valid=1 with select 00,01,10,11 (A=0011, B=0101) -> results 1000,1110,0001,0111 on four consecutive cycles, out_valid continuously 1.
REQ-033 Assert rst_n=0 mid-clock-period while out_valid=1 -> all outputs 0 before the next edge; operation issued the same cycle is not reported after reset release.
